// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin resource scheduler: state encodings
// and the elaboration-time check that gnt_id is wide enough for N_REQ.
package rr_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARB   = 2'b01;
    localparam logic [1:0] ST_GRANT = 2'b10;
    localparam logic [1:0] ST_COOL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARB   = ST_ARB,
        GRANT = ST_GRANT,
        COOL  = ST_COOL
    } sched_state_t;

    function automatic bit id_w_ok(input int n_req, input int id_w);
        return id_w >= $clog2(n_req);
    endfunction

endpackage

// File: rtl/rr_resource_scheduler_pick.sv
// Combinational round-robin picker: lowest requester above last_owner wins,
// otherwise the lowest requester at or below it (wrap-around).
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_owner,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    logic            hi_hit;
    logic [ID_W-1:0] hi_id;
    logic [ID_W-1:0] lo_id;

    always_comb begin
        hi_hit = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        // Descending scan so the last assignment is the lowest matching index.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_id = ID_W'(j);
                if (j > int'(last_owner)) begin
                    hi_hit = 1'b1;
                    hi_id  = ID_W'(j);
                end
            end
        end
        valid  = |req;
        winner = hi_hit ? hi_id : lo_id;
    end

endmodule

// File: rtl/rr_resource_scheduler.sv
// Round-robin scheduler sharing one resource among N_REQ requesters, with a
// programmable hold length, early release and one cool-down cycle per grant.
//
// state | meaning
// IDLE  | no requests pending, resource free
// ARB   | pick next owner round-robin, load hold counter
// GRANT | gnt[owner] high until done, req[owner] drop, or cnt expiry
// COOL  | dead cycle, pointer update, timeout pulse on expiry
module rr_resource_scheduler
    import rr_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int HOLD_W = 4,
    parameter int ID_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              done,
    input  logic [HOLD_W-1:0] hold_len,
    output logic [N_REQ-1:0]  gnt,
    output logic [ID_W-1:0]   gnt_id,
    output logic              busy,
    output logic              timeout,
    output logic [1:0]        state_out
);

    generate
        if (!id_w_ok(N_REQ, ID_W)) begin : g_bad_id_w
            $error("ID_W too narrow for N_REQ");
        end
    endgenerate

    sched_state_t      state;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   last_owner;
    logic [HOLD_W-1:0] cnt;
    logic [ID_W-1:0]   pick_id;
    logic              pick_valid;
    logic              expire;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (pick_id),
        .valid      (pick_valid)
    );

    assign expire    = (cnt == HOLD_W'(1));
    assign state_out = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= ID_W'(N_REQ - 1);
            cnt        <= '0;
            gnt        <= '0;
            gnt_id     <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (pick_valid) begin
                        state  <= GRANT;
                        owner  <= pick_id;
                        gnt_id <= pick_id;
                        gnt    <= N_REQ'(1) << pick_id;
                        cnt    <= (hold_len == '0) ? HOLD_W'(1) : hold_len;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (done || !req[owner] || expire) begin
                        state      <= COOL;
                        gnt        <= '0;
                        last_owner <= owner;
                        // Explicit release (done or req drop) takes precedence over expiry.
                        timeout    <= expire && !done && req[owner];
                    end else begin
                        cnt <= cnt - HOLD_W'(1);
                    end
                end
                COOL: begin
                    if (|req) begin
                        state <= ARB;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
